// File: rtl/maze_pkg.sv
// Shared types and constants for the maze tile-map RAM path.
package maze_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_R0, OWN_R1} owner_t;
  typedef enum logic {RR_R0, RR_R1} rr_ptr_t;

  localparam int unsigned TILE_COLS = 20;
  localparam int unsigned TILE_ROWS = 15;
  localparam int unsigned TILE_PX   = 32;

  // Reads are always eligible; writes may be held off until blanking.
  function automatic logic is_eligible(input logic req, input logic we,
                                       input logic blank, input logic write_in_blank);
    return req && (!we || !write_in_blank || blank);
  endfunction

endpackage

// File: rtl/maze_ram_arbiter_if.sv
// Requester, display and RAM-side signals of the tile-map RAM arbiter.
interface maze_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 4
);
  logic              i_blank;
  logic              i_disp_req;
  logic [ADDR_W-1:0] i_disp_addr;
  logic              o_disp_valid;
  logic [DATA_W-1:0] o_disp_data;

  logic              i_r0_req,    i_r1_req;
  logic              i_r0_we,     i_r1_we;
  logic [ADDR_W-1:0] i_r0_addr,   i_r1_addr;
  logic [DATA_W-1:0] i_r0_wdata,  i_r1_wdata;
  logic              o_r0_gnt,    o_r1_gnt;
  logic              o_r0_rvalid, o_r1_rvalid;
  logic [DATA_W-1:0] o_r0_rdata,  o_r1_rdata;

  logic              o_ram_en;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;

  modport slave (
    input  i_blank, i_disp_req, i_disp_addr,
    output o_disp_valid, o_disp_data,
    input  i_r0_req, i_r0_we, i_r0_addr, i_r0_wdata,
    input  i_r1_req, i_r1_we, i_r1_addr, i_r1_wdata,
    output o_r0_gnt, o_r0_rvalid, o_r0_rdata,
    output o_r1_gnt, o_r1_rvalid, o_r1_rdata,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
    input  i_ram_rdata
  );

  modport master (
    output i_blank, i_disp_req, i_disp_addr,
    input  o_disp_valid, o_disp_data,
    output i_r0_req, i_r0_we, i_r0_addr, i_r0_wdata,
    output i_r1_req, i_r1_we, i_r1_addr, i_r1_wdata,
    input  o_r0_gnt, o_r0_rvalid, o_r0_rdata,
    input  o_r1_gnt, o_r1_rvalid, o_r1_rdata,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
    output i_ram_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the other input after each grant.
module rr_arb2
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);

   rr_ptr_t ptr_q, ptr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= RR_R0;
      else     ptr_q <= ptr_d;
   end

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      if (en_i) begin
         case (elig_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_q == RR_R0) ? 2'b01 : 2'b10;
            default: gnt_o = '0;
         endcase
      end
      if (gnt_o[0])      ptr_d = RR_R1;
      else if (gnt_o[1]) ptr_d = RR_R0;
   end

endmodule

// File: rtl/maze_ram_arbiter.sv
// Single-port tile-map RAM arbiter: display has absolute priority, game requesters share round-robin.
module maze_ram_arbiter
  import maze_pkg::*;
#(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned DATA_W         = 4,
  parameter bit          WRITE_IN_BLANK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  maze_ram_arbiter_if.slave  bus
);

   logic              elig0, elig1;
   logic              disp_go, game_en;
   logic [1:0]        gnt;
   owner_t            tag_q, tag_d;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;

   assign elig0   = is_eligible(bus.i_r0_req, bus.i_r0_we, bus.i_blank, WRITE_IN_BLANK);
   assign elig1   = is_eligible(bus.i_r1_req, bus.i_r1_we, bus.i_blank, WRITE_IN_BLANK);
   // Grants are combinational, so reset must mask them explicitly.
   assign disp_go = !rst && bus.i_disp_req;
   assign game_en = !rst && !bus.i_disp_req;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en_i   (game_en),
      .elig_i ({elig1, elig0}),
      .gnt_o  (gnt)
   );

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      tag_d     = OWN_NONE;
      if (disp_go) begin
         ram_en   = 1'b1;
         ram_addr = bus.i_disp_addr;
         tag_d    = OWN_DISP;
      end else if (gnt[0]) begin
         ram_en    = 1'b1;
         ram_we    = bus.i_r0_we;
         ram_addr  = bus.i_r0_addr;
         ram_wdata = bus.i_r0_wdata;
         tag_d     = bus.i_r0_we ? OWN_NONE : OWN_R0;
      end else if (gnt[1]) begin
         ram_en    = 1'b1;
         ram_we    = bus.i_r1_we;
         ram_addr  = bus.i_r1_addr;
         ram_wdata = bus.i_r1_wdata;
         tag_d     = bus.i_r1_we ? OWN_NONE : OWN_R1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tag_q <= OWN_NONE;
      else     tag_q <= tag_d;
   end

   assign bus.o_ram_en    = ram_en;
   assign bus.o_ram_we    = ram_we;
   assign bus.o_ram_addr  = ram_addr;
   assign bus.o_ram_wdata = ram_wdata;
   assign bus.o_r0_gnt    = gnt[0];
   assign bus.o_r1_gnt    = gnt[1];

   always_comb begin
      bus.o_disp_valid = (tag_q == OWN_DISP);
      bus.o_r0_rvalid  = (tag_q == OWN_R0);
      bus.o_r1_rvalid  = (tag_q == OWN_R1);
      bus.o_disp_data  = bus.o_disp_valid ? bus.i_ram_rdata : '0;
      bus.o_r0_rdata   = bus.o_r0_rvalid  ? bus.i_ram_rdata : '0;
      bus.o_r1_rdata   = bus.o_r1_rvalid  ? bus.i_ram_rdata : '0;
   end

endmodule

// File: doc/maze_ram_arbiter.md
# maze_ram_arbiter

Single-port arbiter for the maze tile-map RAM. It shares the RAM between three requesters: the display fetch path, the maze loader and the player logic. The display fetch path is driven by the VGA sync counters, cannot stall, and has absolute priority. The two game requesters share the remaining slots round-robin, and game writes are optionally restricted to blanking so a frame never tears mid-scan.

## Interface
Parameters:
- ADDR_W, 9, tile-map address width (20x15 = 300 tiles used)
- DATA_W, 4, tile code width
- WRITE_IN_BLANK, 1, when 1 game writes are granted only while i_blank=1; reads are always eligible

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  reset; asynchronous, active-high
- i_blank  in  1  1 outside the visible area (from VGA sync: ~pix_valid)
- i_disp_req  in  1  display read request, one-cycle strobe
- i_disp_addr  in  ADDR_W  display tile address
- o_disp_valid  out  1  display read data valid
- o_disp_data  out  DATA_W  display tile code
- i_rN_req, N=0 (loader), N=1 (player)  in  1  request; held until granted
- i_rN_we  in  1  1 = write, 0 = read
- i_rN_addr  in  ADDR_W  address
- i_rN_wdata  in  DATA_W  write data
- o_rN_gnt  out  1  grant, one-cycle pulse
- o_rN_rvalid  out  1  read data valid
- o_rN_rdata  out  DATA_W  read data
- o_ram_en, o_ram_we  out  1  RAM enable/write enable
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM synchronous read data, 1-cycle latency

## Operation
- Exactly one RAM access per cycle at most. Arbitration is combinational in cycle N; o_ram_* and o_rN_gnt are driven in the same cycle N.
- Priority: the display has absolute priority. A display request is never refused and never delayed.
- A requester is eligible when i_rN_req=1 and (i_rN_we=0 or WRITE_IN_BLANK=0 or i_blank=1).
- With no display request and exactly one eligible requester, that requester is granted.
- With no display request and both requesters eligible, the grant goes to the requester selected by the round-robin pointer rr_ptr.
- rr_ptr update: after granting rN, rr_ptr becomes the other requester. rr_ptr is unchanged on display cycles and idle cycles. It resets to r0.
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt=1. The transfer completes in the gnt cycle. Keeping req high the next cycle is a new request.
- A write takes effect in the gnt cycle. No rvalid is generated for a write.
- Read return: a 2-bit owner tag register holds {NONE, DISP, R0, R1}, loaded each cycle with the owner of the read issued, or NONE for writes and idle cycles. In cycle N+1 the tagged port's valid is asserted, and i_ram_rdata is passed to its data output.
- Data outputs (o_disp_data, o_rN_rdata) are i_ram_rdata when their valid is 1, otherwise 0.
- Reset values: o_ram_en=0, all gnt=0, all valid=0, all data outputs=0, tag=NONE, rr_ptr=r0.

## Timing
- Latency, request to grant: 0 cycles when the display is idle and the requester wins. Otherwise the request waits.
- Latency, grant to read data: 1 cycle. Display: i_disp_req in N gives o_disp_valid in N+1.
- Boundary cases:
  - Display request and game requests in the same cycle: display wins; game gnt=0.
  - Back-to-back display requests: game requests are starved for the duration. This is accepted; the display path issues at most one request per 32 pixels.
  - Write pending while i_blank=0 and WRITE_IN_BLANK=1: the write stays pending with no gnt. The other requester's read may proceed. The write is granted in the first blank cycle in which it wins arbitration.
  - i_blank falling in the grant cycle: a grant already given stands, because eligibility is sampled combinationally.
  - Reset asserted mid-operation: the in-flight read is dropped and no rvalid is produced. rr_ptr returns to r0.

## Structure
- Shared package maze_pkg:
  - owner_t enum {OWN_NONE, OWN_DISP, OWN_R0, OWN_R1}
  - TILE_COLS=20, TILE_ROWS=15, TILE_PX=32
- Sub-module rr_arb2: 2-input round-robin arbiter with eligibility inputs, an enable input (driven low on display cycles), one-hot grant and an internal pointer.
- The top level contains the priority mux, the owner tag register and the read-return demux.

## Test plan
- Reset: hold rst with all requests high → every gnt/valid/data output is 0 and o_ram_en=0. After release with r0 and r1 reading → r0 is granted first.
- Display priority: i_disp_req=1 (addr 5) together with r0 read (addr 7) → o_ram_addr=5 and o_r0_gnt=0. Next cycle, o_disp_valid=1 with the RAM model's data for addr 5, and r0 is granted addr 7.
- Round-robin: r0 and r1 both reading continuously, display idle → grants alternate r0, r1, r0, r1. Each rvalid appears exactly 1 cycle after the matching gnt, with the correct data.
- Blank gating: WRITE_IN_BLANK=1, i_blank=0, r1 write (addr 10, data 4'hA) plus r0 read → only r0 is granted. Raise i_blank → r1 is granted, and a later read of addr 10 returns 4'hA.
- Reset mid-read: r0 read granted in cycle N, rst pulsed in N+1 → o_r0_rvalid stays 0. Requests after release are served normally.
- Starvation bound: display strobe every 32nd cycle, r0 and r1 requesting continuously → no requester waits more than 2 cycles for a grant.
